// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for a 5-stage MIPS pipeline: load-use bubbles,
// EX-resolved branch flushes, data-memory wait holds, event counters and a timeout flag.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout,
  output logic [1:0]       last_reason
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ACT_NONE    = 2'd0,
    ACT_LOADUSE = 2'd1,
    ACT_BRANCH  = 2'd2,
    ACT_MEMWAIT = 2'd3
  } action_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             branch_pend_q, branch_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [1:0]       last_reason_q, last_reason_d;

  logic    freeze_s;
  logic    loaduse_s;
  logic    branch_s;
  action_e action_s;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  function automatic logic [7:0] wait_sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Hazard detection and action selection by priority.
  // A branch seen during a freeze is remembered and applied on the release cycle.
  always_comb begin
    freeze_s  = mem_req & ~mem_ready;
    loaduse_s = ex_memread & (ex_rt != 5'd0) &
                ((id_use_rs & (id_rs == ex_rt)) | (id_use_rt & (id_rt == ex_rt)));
    branch_s  = ex_branch_taken | branch_pend_q;
    action_s  = ACT_NONE;
    if (freeze_s) begin
      action_s = ACT_MEMWAIT;
    end else if (branch_s) begin
      action_s = ACT_BRANCH;
    end else if (loaduse_s) begin
      action_s = ACT_LOADUSE;
    end else begin
      action_s = ACT_NONE;
    end
  end

  // Mealy control outputs; reset forces NOP/bubble injection with all writes blocked.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      case (action_s)
        ACT_MEMWAIT: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_bubble = 1'b1;
        end
        ACT_BRANCH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        ACT_LOADUSE: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
        default: begin
          pc_write = 1'b1;
        end
      endcase
    end
  end

  // Wait FSM next state, wait length tracking and pending-branch capture.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    branch_pend_d = 1'b0;
    if (freeze_s) begin
      branch_pend_d = branch_pend_q | ex_branch_taken;
    end else begin
      branch_pend_d = 1'b0;
    end
    case (state_q)
      ST_RUN: begin
        if (freeze_s) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (freeze_s) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = wait_sat_inc(wait_cnt_q);
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // Counters, sticky timeout and last applied action.
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    mem_timeout_d = mem_timeout_q;
    last_reason_d = last_reason_q;
    if ((action_s == ACT_MEMWAIT) || (action_s == ACT_LOADUSE)) begin
      stall_cnt_d = cnt_sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (action_s == ACT_BRANCH) begin
      flush_cnt_d = cnt_sat_inc(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    // wait_cnt_d already counts the freeze cycle ending at this edge.
    if (freeze_s && (wait_cnt_d >= 8'(MEM_TIMEOUT))) begin
      mem_timeout_d = 1'b1;
    end else begin
      mem_timeout_d = mem_timeout_q;
    end
    if (action_s != ACT_NONE) begin
      last_reason_d = action_s;
    end else begin
      last_reason_d = last_reason_q;
    end
  end

  // State register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= 8'd0;
      branch_pend_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
      last_reason_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      branch_pend_q <= branch_pend_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      last_reason_q <= last_reason_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = mem_timeout_q;
  assign last_reason = last_reason_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations, a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int CNT_W = 2;

  logic clk;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_use_rs, id_use_rt, ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, memwb_bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic mem_timeout;
  logic [1:0] last_reason;

  typedef struct {
    logic [6:0] ctl;
    logic [1:0] sc;
    logic [1:0] fc;
    logic       to;
    logic [1:0] rsn;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, memwb_bubble}
  localparam logic [6:0] NORM = 7'b1111_000;
  localparam logic [6:0] LU   = 7'b0011_010;
  localparam logic [6:0] BR   = 7'b1111_110;
  localparam logic [6:0] FRZ  = 7'b0000_001;
  localparam logic [6:0] RST  = 7'b0000_111;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .memwb_bubble(memwb_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout), .last_reason(last_reason)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [6:0] ctl, input logic [1:0] sc, input logic [1:0] fc,
                      input logic to, input logic [1:0] rsn, input string nm);
    exp_t e;
    e.ctl = ctl; e.sc = sc; e.fc = fc; e.to = to; e.rsn = rsn; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] ert, input logic mr, input logic br,
                       input logic mreq, input logic mrdy);
    id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    ex_rt = ert; ex_memread = mr; ex_branch_taken = br;
    mem_req = mreq; mem_ready = mrdy;
  endtask

  // One cycle: inputs after the rising edge, expectation queued for the monitor.
  task automatic step(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                      input logic [4:0] ert, input logic mr, input logic br,
                      input logic mreq, input logic mrdy,
                      input logic [6:0] ctl, input logic [1:0] sc, input logic [1:0] fc,
                      input logic to, input logic [1:0] rsn, input string nm);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(rs, urs, rt, urt, ert, mr, br, mreq, mrdy);
    push(ctl, sc, fc, to, rsn, nm);
  endtask

  task automatic idle(input logic [1:0] sc, input logic [1:0] fc, input logic to,
                      input logic [1:0] rsn, input string nm);
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, sc, fc, to, rsn, nm);
  endtask

  task automatic frz(input logic br, input logic [1:0] sc, input logic [1:0] fc, input logic to,
                     input logic [1:0] rsn, input string nm);
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, br, 1'b1, 1'b0, FRZ, sc, fc, to, rsn, nm);
  endtask

  task automatic rst_step(input string nm);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(RST, 2'd0, 2'd0, 1'b0, 2'd0, nm);
  endtask

  // Monitor: compare live outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] got;
      e = exp_q.pop_front();
      got = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, memwb_bubble};
      n_tests++;
      if (got !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl: got %b want %b", e.nm, got, e.ctl);
      end
      n_tests++;
      if (stall_cnt !== e.sc) begin
        n_fail++;
        $display("FAIL %s stall_cnt: got %0d want %0d", e.nm, stall_cnt, e.sc);
      end
      n_tests++;
      if (flush_cnt !== e.fc) begin
        n_fail++;
        $display("FAIL %s flush_cnt: got %0d want %0d", e.nm, flush_cnt, e.fc);
      end
      n_tests++;
      if (mem_timeout !== e.to) begin
        n_fail++;
        $display("FAIL %s mem_timeout: got %b want %b", e.nm, mem_timeout, e.to);
      end
      n_tests++;
      if (last_reason !== e.rsn) begin
        n_fail++;
        $display("FAIL %s last_reason: got %0d want %0d", e.nm, last_reason, e.rsn);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_step("reset");
    // Register $0 and unused-operand guards, then load-use via rs and rt
    step(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NORM, 2'd0, 2'd0, 1'b0, 2'd0, "r0_guard");
    step(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, NORM, 2'd0, 2'd0, 1'b0, 2'd0, "rt_unused");
    step(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU,   2'd0, 2'd0, 1'b0, 2'd0, "loaduse_rs");
    idle(2'd1, 2'd0, 1'b0, 2'd1, "after_lu");
    step(5'd2, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, LU,   2'd1, 2'd0, 1'b0, 2'd1, "loaduse_rt");
    idle(2'd2, 2'd0, 1'b0, 2'd1, "after_lu_rt");
    // Branch overrides load-use
    rst_step("reset2");
    step(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, BR,   2'd0, 2'd0, 1'b0, 2'd0, "br_over_lu");
    idle(2'd0, 2'd1, 1'b0, 2'd2, "after_br");
    // Three-cycle memory wait, no timeout
    rst_step("reset3");
    frz(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, "memw1");
    frz(1'b0, 2'd1, 2'd0, 1'b0, 2'd3, "memw2");
    frz(1'b0, 2'd2, 2'd0, 1'b0, 2'd3, "memw3");
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NORM, 2'd3, 2'd0, 1'b0, 2'd3, "memw_rel");
    idle(2'd3, 2'd0, 1'b0, 2'd3, "memw_done");
    // Freeze beats branch; branch applied on release (held and pending cases)
    frz(1'b1, 2'd3, 2'd0, 1'b0, 2'd3, "frz_br1");
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, BR,   2'd3, 2'd0, 1'b0, 2'd3, "rel_br_held");
    idle(2'd3, 2'd1, 1'b0, 2'd2, "after_rel_br");
    frz(1'b1, 2'd3, 2'd1, 1'b0, 2'd2, "frz_br2");
    frz(1'b0, 2'd3, 2'd1, 1'b0, 2'd3, "frz_br_drop");
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, BR,   2'd3, 2'd1, 1'b0, 2'd3, "rel_br_pend");
    idle(2'd3, 2'd2, 1'b0, 2'd2, "after_pend");
    frz(1'b0, 2'd3, 2'd2, 1'b0, 2'd2, "frz_lu");
    step(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, LU,   2'd3, 2'd2, 1'b0, 2'd3, "rel_lu");
    idle(2'd3, 2'd2, 1'b0, 2'd1, "after_rel_lu");
    // Timeout at the edge ending the 4th freeze cycle
    rst_step("reset4");
    frz(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, "to1");
    frz(1'b0, 2'd1, 2'd0, 1'b0, 2'd3, "to2");
    frz(1'b0, 2'd2, 2'd0, 1'b0, 2'd3, "to3");
    frz(1'b0, 2'd3, 2'd0, 1'b0, 2'd3, "to4");
    frz(1'b0, 2'd3, 2'd0, 1'b1, 2'd3, "to5");
    frz(1'b0, 2'd3, 2'd0, 1'b1, 2'd3, "to6");
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NORM, 2'd3, 2'd0, 1'b1, 2'd3, "to_rel");
    idle(2'd3, 2'd0, 1'b1, 2'd3, "to_sticky");
    rst_step("to_clear");
    idle(2'd0, 2'd0, 1'b0, 2'd0, "to_cleared");
    // Flush counter saturation
    for (int i = 0; i < 5; i++) begin
      step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR, 2'd0,
           (i > 3) ? 2'd3 : 2'(i), 1'b0, (i == 0) ? 2'd0 : 2'd2, "br_sat");
    end
    idle(2'd0, 2'd3, 1'b0, 2'd2, "br_sat_hold");
    // Async reset between edges during a wait with a pending branch
    frz(1'b1, 2'd0, 2'd3, 1'b0, 2'd2, "pre_async1");
    frz(1'b1, 2'd1, 2'd3, 1'b0, 2'd3, "pre_async2");
    @(posedge clk); #2;
    rst = 1'b1;
    push(RST, 2'd0, 2'd0, 1'b0, 2'd0, "async_rst");
    #6;
    rst = 1'b0;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2'd0, 2'd0, 1'b0, 2'd0, "pend_dropped");
    idle(2'd0, 2'd0, 1'b0, 2'd0, "post_async");
    repeat (2) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS pipeline. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their write enables, flush and bubble controls. It handles three conditions: load-use hazards, taken-branch flushes resolved in EX, and multi-cycle data-memory waits. It also keeps saturating stall and flush counters and a sticky memory-timeout flag.

## Interface
Parameters:
- CNT_W, 16: width of the performance counters.
- MEM_TIMEOUT, 64: freeze-cycle count at which mem_timeout sets. Legal range 1..255.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt.
- ex_rt  in  5  destination rt of the instruction in EX.
- ex_memread  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_req  in  1  MEM stage holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register enables.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_bubble  out  1  zero the WB/M/EX control fields entering ID/EX.
- memwb_bubble  out  1  zero the control fields entering MEM/WB.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.
- mem_timeout  out  1  sticky; set when a memory wait has lasted too long.
- last_reason  out  2  last applied action: 0 none, 1 load-use, 2 branch, 3 mem wait.

## Operation
Definitions:
- freeze = mem_req & ~mem_ready.
- loaduse = ex_memread & (ex_rt != 0) & ((id_use_rs & id_rs == ex_rt) | (id_use_rt & id_rt == ex_rt)).

Control outputs are combinational (Mealy). Priority is reset > freeze > branch > loaduse > normal:
- rst=1: all *_write=0; ifid_flush=1, idex_bubble=1, memwb_bubble=1.
- freeze: pc_write, ifid_write, idex_write, exmem_write all 0; memwb_bubble=1; ifid_flush=0, idex_bubble=0.
- branch: all writes 1; ifid_flush=1; idex_bubble=1. The PC loads the branch target. Branch overrides loaduse because the ID instruction is squashed.
- loaduse: pc_write=0, ifid_write=0; idex_write=1, exmem_write=1; idex_bubble=1.
- normal: all writes 1; all flush and bubble outputs 0.

FSM states:
- RUN: freeze → MEM_WAIT, wait_cnt=1; otherwise stay in RUN.
- MEM_WAIT: freeze → stay, wait_cnt+1 (saturating at 255); otherwise → RUN, wait_cnt=0.
- Outputs in MEM_WAIT follow the same priority rules. On the release cycle (mem_ready=1), a pending branch or load-use is applied in that same cycle.

Timeout:
- mem_timeout sets at the edge that ends freeze cycle number MEM_TIMEOUT of one wait.
- It stays set until rst. Holding continues regardless; the flag is a diagnostic only.

Counters:
- stall_cnt +1 on each cycle where freeze or loaduse is applied.
- flush_cnt +1 on each cycle where branch is applied.
- Both saturate at 2^CNT_W-1 and never wrap.

last_reason is registered and updates only on cycles with a non-normal action.

## Timing
- Reset values: state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0, last_reason=0. Control outputs take the rst values above asynchronously.
- Control outputs have zero-cycle latency from their inputs. Counters, last_reason and mem_timeout reflect an event one edge later.
- A load-use produces exactly one bubble. The next cycle EX holds a bubble (ex_memread=0), so the hazard is not re-detected.
- A freeze lasting N cycles holds PC, IF/ID, ID/EX and EX/MEM for N cycles and injects N MEM/WB bubbles.
- Reset asserted mid-wait returns to RUN immediately, clears all counters and the flag, and discards any pending branch.
- Register $0 never causes a hazard.
- Simultaneous freeze and branch: freeze wins and the branch is applied when freeze drops.

## Test plan
- Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_use_rs=1, one cycle → pc_write=0, ifid_write=0, idex_bubble=1; next edge stall_cnt=1, last_reason=1.
- $0 guard: same stimulus as load-use but ex_rt=0 → normal outputs; stall_cnt remains 0.
- Branch with load-use: ex_branch_taken=1 together with a load-use → ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1 and stall_cnt=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → 3 cycles of all enables 0 and memwb_bubble=1; state returns to RUN after the release edge; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, freeze for 6 cycles → mem_timeout rises after the 4th freeze edge and stays 1 after release; rst clears it.
- Counter saturation and async reset: CNT_W=2 with 5 branch cycles → flush_cnt=3. Pulse rst between clock edges → counters clear immediately and outputs show rst values.
